// File: rtl/nes_pkg.sv
// Shared definitions for the NES pad scanner: button bit positions and
// the scan FSM state encoding.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int BITS_PER_PAD = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } nes_state_e;

endpackage

// File: rtl/nes_pad_scanner_if.sv
// Pad pins, control inputs and published button state of the scanner.
// The scanner uses the master view; the game datapath uses the slave view.
interface nes_pad_scanner_if #(
  parameter int NUM_PADS = 2
);

  logic                    scan_en;
  logic                    repeat_en;
  logic [NUM_PADS-1:0]     nes_data;
  logic                    nes_latch;
  logic                    nes_clk;
  logic [8*NUM_PADS-1:0]   buttons;
  logic [8*NUM_PADS-1:0]   pressed;
  logic [8*NUM_PADS-1:0]   released;
  logic                    frame_valid;

  modport master (
    input  scan_en, repeat_en, nes_data,
    output nes_latch, nes_clk, buttons, pressed, released, frame_valid
  );

  modport slave (
    output scan_en, repeat_en, nes_data,
    input  nes_latch, nes_clk, buttons, pressed, released, frame_valid
  );

endinterface

// File: rtl/nes_pad_channel.sv
// Per-pad datapath: serial capture, held-button register, edge pulses and
// the auto-repeat hold counter, all driven by strobes from the shared FSM.
module nes_pad_channel
  import nes_pkg::*;
#(
  parameter int REPEAT_FRAMES = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_data,
  input  logic       i_sample,
  input  logic [2:0] i_bit_idx,
  input  logic       i_done,
  input  logic       i_repeat_en,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released
);

  localparam int HW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_FRAMES - 1);

  logic [BITS_PER_PAD-1:0] r_shreg;
  logic [BITS_PER_PAD-1:0] r_buttons;
  logic [BITS_PER_PAD-1:0] r_pressed;
  logic [BITS_PER_PAD-1:0] r_released;
  logic [HW-1:0]           r_hold_cnt;
  logic                    w_changed;

  assign w_changed = (r_shreg != r_buttons);

  // Pad data is active-low; store it active-high at the current bit slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shreg <= 8'h00;
    end else if (i_sample) begin
      r_shreg[i_bit_idx] <= ~i_data;
    end
  end

  // Publish the finished scan: a change always wins over a repeat pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buttons  <= 8'h00;
      r_pressed  <= 8'h00;
      r_released <= 8'h00;
      r_hold_cnt <= '0;
    end else if (i_done) begin
      r_buttons <= r_shreg;
      if (w_changed) begin
        r_pressed  <= r_shreg & ~r_buttons;
        r_released <= ~r_shreg & r_buttons;
        r_hold_cnt <= '0;
      end else if (!i_repeat_en || (r_shreg == 8'h00)) begin
        r_pressed  <= 8'h00;
        r_released <= 8'h00;
        r_hold_cnt <= '0;
      end else if (r_hold_cnt == HOLD_LAST) begin
        r_pressed  <= r_shreg;
        r_released <= 8'h00;
        r_hold_cnt <= '0;
      end else begin
        r_pressed  <= 8'h00;
        r_released <= 8'h00;
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end else begin
      r_pressed  <= 8'h00;
      r_released <= 8'h00;
    end
  end

  assign o_buttons  = r_buttons;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;

endmodule

// File: rtl/nes_pad_scanner.sv
// Frame-rate poller for NUM_PADS NES controllers sharing one latch and one
// shift clock; the FSM sequences the pins, the channels hold per-pad state.
module nes_pad_scanner
  import nes_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int BIT_DIV       = 152,
  parameter int POLL_DIV      = 419583,
  parameter int REPEAT_FRAMES = 15
) (
  input logic               clk,
  input logic               reset,
  nes_pad_scanner_if.master bus
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int PW = $clog2(2 * BIT_DIV);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(BIT_DIV - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * BIT_DIV - 1);

  nes_state_e            r_state;
  nes_state_e            w_state_nxt;
  logic [CW-1:0]         r_poll_cnt;
  logic [PW-1:0]         r_phase;
  logic [2:0]            r_bit_idx;
  logic                  r_latch;
  logic                  r_clk;
  logic                  r_frame_valid;
  logic                  w_poll_tc;
  logic                  w_phase_last;
  logic                  w_latch_nxt;
  logic                  w_clk_nxt;
  logic                  w_sample;
  logic                  w_done;
  logic [8*NUM_PADS-1:0] w_buttons;
  logic [8*NUM_PADS-1:0] w_pressed;
  logic [8*NUM_PADS-1:0] w_released;

  assign w_poll_tc    = bus.scan_en && (r_poll_cnt == POLL_LAST);
  assign w_phase_last = (r_state == ST_LATCH) ? (r_phase == LATCH_LAST)
                                              : (r_phase == HALF_LAST);
  assign w_sample     = (r_state == ST_SHIFT_LO) && w_phase_last;
  assign w_done       = (r_state == ST_DONE);

  // Free-running frame counter; parked at zero while polling is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_cnt <= '0;
    end else if (!bus.scan_en || w_poll_tc) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + CW'(1);
    end
  end

  // Next state and next pin levels.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_poll_tc) w_state_nxt = ST_LATCH;
        else           w_state_nxt = ST_IDLE;
      end
      ST_LATCH: begin
        if (w_phase_last) w_state_nxt = ST_SHIFT_LO;
        else              w_state_nxt = ST_LATCH;
      end
      ST_SHIFT_LO: begin
        if (!w_phase_last)                     w_state_nxt = ST_SHIFT_LO;
        else if (r_bit_idx == 3'(BTN_RIGHT))   w_state_nxt = ST_DONE;
        else                                   w_state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (w_phase_last) w_state_nxt = ST_SHIFT_LO;
        else              w_state_nxt = ST_SHIFT_HI;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_latch_nxt = (w_state_nxt == ST_LATCH);
    w_clk_nxt   = (w_state_nxt == ST_SHIFT_HI);
  end

  // State register with pin and frame_valid registers alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_latch       <= 1'b0;
      r_clk         <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_latch       <= w_latch_nxt;
      r_clk         <= w_clk_nxt;
      r_frame_valid <= w_done;
    end
  end

  // Phase timer restarts at every state boundary; bit index advances after each high phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= '0;
      r_bit_idx <= 3'd0;
    end else begin
      if ((r_state == ST_IDLE) || (r_state == ST_DONE) || w_phase_last) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PW'(1);
      end
      if (r_state == ST_LATCH) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == ST_SHIFT_HI) && w_phase_last) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_bit_idx <= r_bit_idx;
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    nes_pad_channel #(
      .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_channel (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_data      (bus.nes_data[p]),
      .i_sample    (w_sample),
      .i_bit_idx   (r_bit_idx),
      .i_done      (w_done),
      .i_repeat_en (bus.repeat_en),
      .o_buttons   (w_buttons[8*p +: 8]),
      .o_pressed   (w_pressed[8*p +: 8]),
      .o_released  (w_released[8*p +: 8])
    );
  end

  assign bus.nes_latch   = r_latch;
  assign bus.nes_clk     = r_clk;
  assign bus.frame_valid = r_frame_valid;
  assign bus.buttons     = w_buttons;
  assign bus.pressed     = w_pressed;
  assign bus.released    = w_released;

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Bench for nes_pad_scanner: emulated pads, per-cycle pin timing, and a
// frame-level button model covering edges and auto-repeat.
module tb_nes_pad_scanner;

  localparam int NP = 2;
  localparam int BD = 2;
  localparam int PD = 64;
  localparam int RF = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  nes_pad_scanner_if #(.NUM_PADS(NP)) bus ();

  nes_pad_scanner #(
    .NUM_PADS(NP), .BIT_DIV(BD), .POLL_DIV(PD), .REPEAT_FRAMES(RF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Emulated controllers: latch reloads, each rising shift clock moves to the next button.
  logic [7:0] pad_btn [NP];
  int         pad_pos = 0;

  always @(posedge bus.nes_latch or posedge bus.nes_clk) begin
    if (bus.nes_latch) pad_pos <= 0;
    else               pad_pos <= pad_pos + 1;
  end

  always_comb begin
    bus.nes_data = '1;
    for (int p = 0; p < NP; p++)
      bus.nes_data[p] = (pad_pos < 8) ? ~pad_btn[p][pad_pos[2:0]] : 1'b1;
  end

  // Frame-level reference model.
  logic [7:0]  m_btn [NP];
  int          m_run [NP];
  logic [15:0] e_btn, e_pr, e_rl;

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_btn[p] = 8'h00;
      m_run[p] = 0;
    end
  endfunction

  function automatic void model_frame(input bit rep);
    for (int p = 0; p < NP; p++) begin
      logic [7:0] nv, pr, rl;
      nv = pad_btn[p];
      pr = 8'h00;
      rl = 8'h00;
      if (nv != m_btn[p]) begin
        pr = nv & ~m_btn[p];
        rl = ~nv & m_btn[p];
        m_run[p] = 0;
      end else if (rep && nv != 8'h00) begin
        m_run[p]++;
        if (m_run[p] == RF) begin
          pr = nv;
          m_run[p] = 0;
        end
      end else begin
        m_run[p] = 0;
      end
      m_btn[p] = nv;
      e_btn[8*p +: 8] = nv;
      e_pr[8*p +: 8]  = pr;
      e_rl[8*p +: 8]  = rl;
    end
  endfunction

  function automatic bit exp_latch(input int t);
    return (t >= PD) && ((t % PD) < 2*BD);
  endfunction

  function automatic bit exp_nclk(input int t);
    int o;
    o = t % PD;
    return (t >= PD) && (o >= 4*BD - 2*BD) && (o < 2*BD + 14*BD) && (((o - 2*BD) % (2*BD)) >= BD);
  endfunction

  task automatic wait_fv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.scan_en = 1'b0;
    bus.repeat_en = 1'b0;
    pad_btn[0] = 8'h00;
    pad_btn[1] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.nes_latch !== 1'b0) begin n_err++; $display("FAIL reset_latch: got %b want 0", bus.nes_latch); end
    n_cmp++; if (bus.nes_clk !== 1'b0) begin n_err++; $display("FAIL reset_clk: got %b want 0", bus.nes_clk); end
    n_cmp++; if (bus.buttons !== 16'h0000) begin n_err++; $display("FAIL reset_buttons: got %h want 0000", bus.buttons); end
    n_cmp++; if (bus.pressed !== 16'h0000) begin n_err++; $display("FAIL reset_pressed: got %h want 0000", bus.pressed); end
    n_cmp++; if (bus.released !== 16'h0000) begin n_err++; $display("FAIL reset_released: got %h want 0000", bus.released); end
    n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b want 0", bus.frame_valid); end
    reset = 1'b0;
    begin
      int lat;
      lat = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (bus.nes_latch) lat++;
      end
      n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL idle_no_latch: got %0d latch cycles want 0", lat); end
    end
  endtask

  task automatic test_timing();
    int rises;
    logic prev_clk;
    rises = 0;
    prev_clk = 1'b0;
    bus.scan_en = 1'b1;
    for (int t = 1; t <= 170; t++) begin
      @(negedge clk);
      n_cmp++; if (bus.nes_latch !== exp_latch(t)) begin n_err++; $display("FAIL timing_latch t=%0d: got %b want %b", t, bus.nes_latch, exp_latch(t)); end
      n_cmp++; if (bus.nes_clk !== exp_nclk(t)) begin n_err++; $display("FAIL timing_clk t=%0d: got %b want %b", t, bus.nes_clk, exp_nclk(t)); end
      n_cmp++; if (bus.frame_valid !== (t >= PD && (t % PD) == 17*BD + 1)) begin n_err++; $display("FAIL timing_fv t=%0d: got %b", t, bus.frame_valid); end
      if (bus.nes_clk && !prev_clk && t < 2*PD) rises++;
      prev_clk = bus.nes_clk;
      if (bus.frame_valid) begin
        model_frame(bus.repeat_en);
        n_cmp++; if (bus.buttons !== e_btn) begin n_err++; $display("FAIL timing_buttons: got %h want %h", bus.buttons, e_btn); end
      end
    end
    n_cmp++; if (rises !== 7) begin n_err++; $display("FAIL clk_pulses: got %0d want 7", rises); end
  endtask

  task automatic test_press_release();
    logic [7:0] s0 [5];
    logic [7:0] s1 [5];
    bit ok;
    s0 = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    s1 = '{8'h00, 8'h00, 8'h08, 8'h08, 8'h00};
    bus.repeat_en = 1'b0;
    for (int f = 0; f < 5; f++) begin
      pad_btn[0] = s0[f];
      pad_btn[1] = s1[f];
      wait_fv(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL press_fv_timeout f=%0d: got none want frame_valid", f); end
      model_frame(bus.repeat_en);
      n_cmp++; if (bus.buttons !== e_btn) begin n_err++; $display("FAIL press_buttons f=%0d: got %h want %h", f, bus.buttons, e_btn); end
      n_cmp++; if (bus.pressed !== e_pr) begin n_err++; $display("FAIL press_pressed f=%0d: got %h want %h", f, bus.pressed, e_pr); end
      n_cmp++; if (bus.released !== e_rl) begin n_err++; $display("FAIL press_released f=%0d: got %h want %h", f, bus.released, e_rl); end
      if (f == 0) begin
        n_cmp++; if (bus.pressed !== 16'h0011) begin n_err++; $display("FAIL press_a_up: got %h want 0011", bus.pressed); end
        @(negedge clk);
        n_cmp++; if (bus.pressed !== 16'h0000 || bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL press_one_cycle: got %h/%b want 0000/0", bus.pressed, bus.frame_valid); end
      end
      if (f == 4) begin
        n_cmp++; if (bus.released[11] !== 1'b1 || bus.buttons[11] !== 1'b0) begin n_err++; $display("FAIL start_release: got rel=%b btn=%b want 1/0", bus.released[11], bus.buttons[11]); end
      end
    end
  endtask

  task automatic test_repeat();
    bit ok;
    for (int phase = 0; phase < 2; phase++) begin
      bus.repeat_en = (phase == 0);
      for (int f = 0; f < 8; f++) begin
        pad_btn[0] = (phase == 1 && f == 0) ? 8'h00 : 8'h02;
        pad_btn[1] = 8'h00;
        wait_fv(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL repeat_fv_timeout f=%0d: got none want frame_valid", f); end
        model_frame(bus.repeat_en);
        n_cmp++; if (bus.pressed !== e_pr) begin n_err++; $display("FAIL repeat_pressed p%0d f=%0d: got %h want %h", phase, f, bus.pressed, e_pr); end
        n_cmp++; if (bus.released !== e_rl) begin n_err++; $display("FAIL repeat_released p%0d f=%0d: got %h want %h", phase, f, bus.released, e_rl); end
        if (phase == 0) begin
          n_cmp++; if (bus.pressed[1] !== ((f % 3) == 0)) begin n_err++; $display("FAIL repeat_b_pulse f=%0d: got %b want %b", f, bus.pressed[1], (f % 3) == 0); end
        end else begin
          n_cmp++; if (bus.pressed[1] !== (f == 1)) begin n_err++; $display("FAIL norepeat_b_pulse f=%0d: got %b want %b", f, bus.pressed[1], f == 1); end
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 24; f++) begin
      if ((f % 6) == 0) bus.repeat_en = 1'($urandom_range(0, 1));
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) != 0) pad_btn[p] = 8'($urandom);
      wait_fv(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_fv_timeout f=%0d: got none want frame_valid", f); end
      model_frame(bus.repeat_en);
      n_cmp++; if (bus.buttons !== e_btn) begin n_err++; $display("FAIL rand_buttons f=%0d: got %h want %h", f, bus.buttons, e_btn); end
      n_cmp++; if (bus.pressed !== e_pr) begin n_err++; $display("FAIL rand_pressed f=%0d: got %h want %h", f, bus.pressed, e_pr); end
      n_cmp++; if (bus.released !== e_rl) begin n_err++; $display("FAIL rand_released f=%0d: got %h want %h", f, bus.released, e_rl); end
    end
  endtask

  task automatic test_reset_midscan();
    bit ok;
    bit seen;
    wait_fv(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_fv_timeout: got none want frame_valid"); end
    model_frame(bus.repeat_en);
    n_cmp++; if (bus.buttons !== e_btn) begin n_err++; $display("FAIL mid_pre_buttons: got %h want %h", bus.buttons, e_btn); end
    pad_btn[0] = 8'hA5;
    pad_btn[1] = 8'h3C;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.nes_latch;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL mid_latch_timeout: got none want latch"); end
    repeat (2*BD + 3*2*BD + BD) @(negedge clk);
    n_cmp++; if (bus.nes_clk !== 1'b1) begin n_err++; $display("FAIL mid_in_shift_hi: got clk=%b want 1", bus.nes_clk); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.nes_latch !== 1'b0 || bus.nes_clk !== 1'b0) begin n_err++; $display("FAIL mid_pins: got %b%b want 00", bus.nes_latch, bus.nes_clk); end
    n_cmp++; if (bus.buttons !== 16'h0000 || bus.pressed !== 16'h0000 || bus.released !== 16'h0000 || bus.frame_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_outputs: got %h %h %h %b want zeros", bus.buttons, bus.pressed, bus.released, bus.frame_valid);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int t = 1; t <= PD + 1; t++) begin
      @(negedge clk);
      n_cmp++; if (bus.nes_latch !== (t >= PD)) begin n_err++; $display("FAIL mid_relatch t=%0d: got %b want %b", t, bus.nes_latch, t >= PD); end
    end
  endtask

  task automatic test_scan_en_stop();
    bit ok;
    int lat, fvs;
    bus.scan_en = 1'b0;
    wait_fv(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stop_fv_timeout: got none want frame_valid"); end
    model_frame(bus.repeat_en);
    n_cmp++; if (bus.buttons !== e_btn) begin n_err++; $display("FAIL stop_buttons: got %h want %h", bus.buttons, e_btn); end
    n_cmp++; if (bus.pressed !== e_pr) begin n_err++; $display("FAIL stop_pressed: got %h want %h", bus.pressed, e_pr); end
    lat = 0;
    fvs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.nes_latch) lat++;
      if (bus.frame_valid) fvs++;
    end
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL stop_no_latch: got %0d want 0", lat); end
    n_cmp++; if (fvs !== 0) begin n_err++; $display("FAIL stop_no_fv: got %0d want 0", fvs); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_press_release();
    test_repeat();
    test_random();
    test_reset_midscan();
    test_scan_en_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
